ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It is the outbound counterpart of keyboard_input, which only receives scan codes. The block drives the shared PS/2 clock and data lines open-drain, using the inhibit / request-to-send / device-clocked frame / ACK sequence. It sits beside keyboard_input in the top level; keyboard_input ignores line activity while this block reports not-ready.

---
 rtl/ps2_pkg.sv | 44 ++++
 rtl/ps2_sync_edge.sv | 40 ++++
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encodings, command bytes and small helpers
// used by the host transmitter (and by keyboard_input for the receive side).
package ps2_pkg;

    // Transmitter FSM states
    typedef logic [2:0] ps2_state_t;

    localparam ps2_state_t ST_IDLE    = 3'd0;
    localparam ps2_state_t ST_INHIBIT = 3'd1;
    localparam ps2_state_t ST_RTS     = 3'd2;
    localparam ps2_state_t ST_FRAME   = 3'd3;
    localparam ps2_state_t ST_DONE    = 3'd4;

    // Common host-to-keyboard commands and the device acknowledge byte
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~(^d);
    endfunction

    // Largest of three cycle counts, used to size the shared down-counter
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the raw PS/2 clock and data pins plus a falling
// edge detector on the synchronised clock. Lines idle high, so the flops reset
// to 1 and no spurious fall is reported coming out of reset.
module ps2_sync_edge (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic fall_o,
    output logic dat_sync_o
);

    logic clk_meta_q;
    logic clk_sync_q;
    logic clk_prev_q;
    logic dat_meta_q;
    logic dat_sync_q;

    // Synchronise both pins and keep the previous synced clock for edge detect
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_i;
            dat_sync_q <= dat_meta_q;
        end
    end

    // A fall needs a genuine synced 1->0 transition; a held-low clock gives one fall
    assign fall_o     = clk_prev_q & ~clk_sync_q;
    assign dat_sync_o = dat_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter. Inhibits the bus, issues
// request-to-send, shifts out data/parity/stop on device clock falls and
// samples the device ACK. Both lines are driven open-drain via *_oe.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned SETUP_CYCLES   = 50,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);

    localparam int unsigned CNT_MAX = max3(INHIBIT_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] BIT_PARITY = 4'd8;
    localparam logic [3:0] BIT_ACK    = 4'd10;

    ps2_state_t       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]       bitn_q,   bitn_d;
    logic [7:0]       sh_q,     sh_d;
    logic             par_q,    par_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q,   done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             err_q,    err_d;

    logic             fall_s;
    logic             dat_sync_s;
    logic             accept_s;

    ps2_sync_edge u_sync (
        .clk_i      (clk),
        .resetn_i   (resetn),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_dat_i  (ps2_dat_in),
        .fall_o     (fall_s),
        .dat_sync_o (dat_sync_s)
    );

    assign tx_ready = (state_q == ST_IDLE) && resetn;
    assign accept_s = tx_valid && tx_ready;

    // Next-state logic for the inhibit / RTS / frame / ACK sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitn_d   = bitn_q;
        sh_d     = sh_q;
        par_d    = par_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        ack_ok_d = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (accept_s) begin
                    sh_d     = tx_data;
                    par_d    = odd_parity(tx_data);
                    cnt_d    = INHIBIT_LOAD;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_INHIBIT: begin
                if (cnt_q == '0) begin
                    // Data low while clock is still held low: request-to-send / start bit
                    cnt_d    = SETUP_LOAD;
                    dat_oe_d = 1'b1;
                    state_d  = ST_RTS;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_RTS: begin
                if (cnt_q == '0) begin
                    // Hand the clock to the device; start bit stays on data
                    clk_oe_d = 1'b0;
                    cnt_d    = TIMEOUT_LOAD;
                    bitn_d   = 4'd0;
                    state_d  = ST_FRAME;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_FRAME: begin
                clk_oe_d = 1'b0;
                if (fall_s) begin
                    if (bitn_q >= BIT_ACK) begin
                        // Device pulls data low during this clock pulse to acknowledge
                        done_d   = 1'b1;
                        ack_ok_d = ~dat_sync_s;
                        dat_oe_d = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        if (bitn_q < BIT_PARITY) begin
                            dat_oe_d = ~sh_q[bitn_q[2:0]];
                        end else if (bitn_q == BIT_PARITY) begin
                            dat_oe_d = ~par_q;
                        end else begin
                            dat_oe_d = 1'b0;
                        end
                        bitn_d = bitn_q + 4'd1;
                        cnt_d  = TIMEOUT_LOAD;
                    end
                end else if (cnt_q == '0) begin
                    // Device went silent: abandon the frame and free the bus
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_DONE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases both lines immediately
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitn_q   <= 4'd0;
            sh_q     <= 8'h00;
            par_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitn_q   <= bitn_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            ack_ok_q <= ack_ok_d;
            err_q    <= err_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign tx_done    = done_q;
    assign tx_ack_ok  = ack_ok_q;
    assign tx_error   = err_q;

endmodule
